// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : External asynchronous SRAM controller. Arbitrates between
//            CHANNELS request/acknowledge ports and drives the SRAM pins with
//            WAIT_STATES extra access cycles and one recovery cycle. The
//            tristate buffer for the data pins lives in the top level.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_W      SRAM address width
//   DATA_W      SRAM data width
//   CHANNELS    number of requester ports (1..8), channel 0 is the CPU
//   WAIT_STATES extra ACCESS cycles beyond the first (0..15)
// Ports:
//   iClk, iResetN            clock, asynchronous active-low reset
//   iReq/iWe                 per-channel request level and direction (1=write)
//   iAddr/iData              packed per-channel address and write data
//   oAck                     one-cycle completion pulse, one-hot or zero
//   oData                    read data, valid with oAck, held until next read
//   oSramA/oSramDOut         SRAM address and write data
//   oSramDOe                 1 = FPGA drives the SRAM data bus
//   iSramD                   SRAM data bus input
//   oSramCe1N/oSramCe2       chip enables (Ce2 tied high)
//   oSramOeN/oSramWeN        output enable / write enable, active low
// Build option:
//   SRAM_CTRL_RR_ARB_EN      defined   -> round-robin arbitration
//                            undefined -> fixed priority, lowest index wins
// ============================================================================
module sram_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 8,
    parameter int CHANNELS    = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic                         iClk,
    input  logic                         iResetN,
    input  logic [CHANNELS-1:0]          iReq,
    input  logic [CHANNELS-1:0]          iWe,
    input  logic [CHANNELS*ADDR_W-1:0]   iAddr,
    input  logic [CHANNELS*DATA_W-1:0]   iData,
    output logic [CHANNELS-1:0]          oAck,
    output logic [DATA_W-1:0]            oData,
    output logic [ADDR_W-1:0]            oSramA,
    output logic [DATA_W-1:0]            oSramDOut,
    output logic                         oSramDOe,
    input  logic [DATA_W-1:0]            iSramD,
    output logic                         oSramCe1N,
    output logic                         oSramCe2,
    output logic                         oSramOeN,
    output logic                         oSramWeN
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [3:0]          c_wait_load = 4'(WAIT_STATES);
    localparam logic [CHANNELS-1:0] c_ack_lsb   = CHANNELS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_grant;
    logic             r_we;
    logic [3:0]       r_wait;

    logic             w_any_req;
    logic [IDX_W-1:0] w_gnt;
    logic             w_gnt_we;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_data;

    assign w_any_req  = |iReq;
    assign w_gnt_we   = iWe[w_gnt];
    assign w_gnt_addr = iAddr[int'(w_gnt) * ADDR_W +: ADDR_W];
    assign w_gnt_data = iData[int'(w_gnt) * DATA_W +: DATA_W];

    // The second chip enable is not used for power control on this board.
    assign oSramCe2 = 1'b1;

    // ------------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------------
`ifdef SRAM_CTRL_RR_ARB_EN
    localparam logic [IDX_W-1:0] c_ptr_init = IDX_W'(CHANNELS - 1);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_hi;
    logic [IDX_W-1:0] w_lo;
    logic             w_hi_hit;

    // Round-robin search starting at r_ptr+1 and wrapping. Channels above
    // the pointer form the first search window, the rest (including the
    // pointer itself) the wrapped window. A descending scan lets the lowest
    // requesting index of each window overwrite the earlier candidates.
    always_comb begin
        w_hi     = '0;
        w_lo     = '0;
        w_hi_hit = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (iReq[i]) begin
                if (i > int'(r_ptr)) begin
                    w_hi     = IDX_W'(i);
                    w_hi_hit = 1'b1;
                end else begin
                    w_lo     = IDX_W'(i);
                end
            end
        end
        w_gnt = w_hi_hit ? w_hi : w_lo;
    end

    // Reset value CHANNELS-1 makes channel 0 the first winner.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            r_ptr <= c_ptr_init;
        end else if ((r_state == S_IDLE) && w_any_req) begin
            r_ptr <= w_gnt;
        end
    end
`else
    // Fixed priority: descending scan so the lowest requesting index wins.
    always_comb begin
        w_gnt = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (iReq[i]) begin
                w_gnt = IDX_W'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Access sequencer. Every SRAM pin is a register so the strobes are
    // glitch-free; the pin values for a state are loaded on the edge that
    // enters that state.
    // ------------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_we      <= 1'b0;
            r_wait    <= '0;
            oAck      <= '0;
            oData     <= '0;
            oSramA    <= '0;
            oSramDOut <= '0;
            oSramDOe  <= 1'b0;
            oSramCe1N <= 1'b1;
            oSramOeN  <= 1'b1;
            oSramWeN  <= 1'b1;
        end else begin
            oAck <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        // Latch the whole request; later changes on the
                        // granted port are ignored until its next grant.
                        r_state   <= S_ACCESS;
                        r_grant   <= w_gnt;
                        r_we      <= w_gnt_we;
                        r_wait    <= c_wait_load;
                        oSramA    <= w_gnt_addr;
                        oSramCe1N <= 1'b0;
                        if (w_gnt_we) begin
                            oSramWeN  <= 1'b0;
                            oSramDOe  <= 1'b1;
                            oSramDOut <= w_gnt_data;
                        end else begin
                            oSramOeN  <= 1'b0;
                            oSramDOe  <= 1'b0;
                        end
                    end
                end

                S_ACCESS: begin
                    if (r_wait == 4'd0) begin
                        // Strobes rise together with the ack; on a write the
                        // data bus stays driven through RECOVER for hold time.
                        r_state  <= S_RECOVER;
                        oSramOeN <= 1'b1;
                        oSramWeN <= 1'b1;
                        oAck     <= c_ack_lsb << r_grant;
                        if (!r_we) begin
                            oData <= iSramD;
                        end
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end

                S_RECOVER: begin
                    r_state   <= S_IDLE;
                    oSramCe1N <= 1'b1;
                    oSramDOe  <= 1'b0;
                end

                default: begin
                    r_state   <= S_IDLE;
                    oSramCe1N <= 1'b1;
                    oSramOeN  <= 1'b1;
                    oSramWeN  <= 1'b1;
                    oSramDOe  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl
// Purpose  : Directed self-checking bench for sram_ctrl. Instance "a" runs
//            with WAIT_STATES=0, instance "b" with WAIT_STATES=2; each has a
//            behavioural asynchronous SRAM attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

`ifdef SRAM_CTRL_RR_ARB_EN
    localparam bit c_rr = 1'b1;
`else
    localparam bit c_rr = 1'b0;
`endif

    logic        clk = 1'b0;
    always #50 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance a (WAIT_STATES = 0) ----------------
    logic        rst_n_a = 1'b0;
    logic [1:0]  req_a = '0, we_a = '0, ack_a;
    logic [39:0] addr_a = '0;
    logic [15:0] data_a = '0;
    logic [7:0]  odata_a, dout_a, din_a;
    logic [19:0] sa_a;
    logic        doe_a, ce1_a, ce2_a, oe_a, wen_a;
    logic [7:0]  mem_a [0:1048575];

    sram_ctrl #(.ADDR_W(20), .DATA_W(8), .CHANNELS(2), .WAIT_STATES(0)) u_a (
        .iClk(clk), .iResetN(rst_n_a), .iReq(req_a), .iWe(we_a),
        .iAddr(addr_a), .iData(data_a), .oAck(ack_a), .oData(odata_a),
        .oSramA(sa_a), .oSramDOut(dout_a), .oSramDOe(doe_a), .iSramD(din_a),
        .oSramCe1N(ce1_a), .oSramCe2(ce2_a), .oSramOeN(oe_a), .oSramWeN(wen_a)
    );
    assign din_a = (!ce1_a && !oe_a) ? mem_a[sa_a] : 8'h00;
    always @(posedge wen_a) if (!ce1_a && doe_a) mem_a[sa_a] = dout_a;

    // ---------------- instance b (WAIT_STATES = 2) ----------------
    logic        rst_n_b = 1'b0;
    logic [1:0]  req_b = '0, we_b = '0, ack_b;
    logic [39:0] addr_b = '0;
    logic [15:0] data_b = '0;
    logic [7:0]  odata_b, dout_b, din_b;
    logic [19:0] sa_b;
    logic        doe_b, ce1_b, ce2_b, oe_b, wen_b;
    logic [7:0]  mem_b [0:1048575];

    sram_ctrl #(.ADDR_W(20), .DATA_W(8), .CHANNELS(2), .WAIT_STATES(2)) u_b (
        .iClk(clk), .iResetN(rst_n_b), .iReq(req_b), .iWe(we_b),
        .iAddr(addr_b), .iData(data_b), .oAck(ack_b), .oData(odata_b),
        .oSramA(sa_b), .oSramDOut(dout_b), .oSramDOe(doe_b), .iSramD(din_b),
        .oSramCe1N(ce1_b), .oSramCe2(ce2_b), .oSramOeN(oe_b), .oSramWeN(wen_b)
    );
    assign din_b = (!ce1_b && !oe_b) ? mem_b[sa_b] : 8'h00;
    always @(posedge wen_b) if (!ce1_b && doe_b) mem_b[sa_b] = dout_b;

    // ---------------- protocol monitor, every cycle ----------------
    always @(negedge clk) begin
        if (rst_n_a) begin
            n_tests++;
            if ((!oe_a && !wen_a) || !$onehot0(ack_a) || (doe_a && !oe_a)) begin
                n_fail++;
                $display("FAIL protocol_a: oe_n=%b we_n=%b ack=%b doe=%b, required strobes not both low, ack one-hot0, doe=0 while oe_n=0",
                         oe_a, wen_a, ack_a, doe_a);
            end
        end
        if (rst_n_b) begin
            n_tests++;
            if ((!oe_b && !wen_b) || !$onehot0(ack_b) || (doe_b && !oe_b)) begin
                n_fail++;
                $display("FAIL protocol_b: oe_n=%b we_n=%b ack=%b doe=%b, required strobes not both low, ack one-hot0, doe=0 while oe_n=0",
                         oe_b, wen_b, ack_b, doe_b);
            end
        end
    end

    // ------------------------------------------------------------------
    task automatic test_reset;
        logic [31:0] got;
        logic [31:0] exp;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        repeat (2) @(negedge clk);
        got = {ack_a, odata_a, dout_a, doe_a, ce1_a, ce2_a, oe_a, wen_a, 3'b000};
        exp = {2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_pins_a: got %h required %h", got, exp);
        end
        n_tests++;
        if (sa_a !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_addr_a: got %h required 00000", sa_a);
        end
        got = {ack_b, odata_b, dout_b, doe_b, ce1_b, ce2_b, oe_b, wen_b, 3'b000};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_pins_b: got %h required %h", got, exp);
        end
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        @(negedge clk);
    endtask

    // Channel 0 reads 0x5A from 0x12345 on instance a.
    task automatic test_single_read;
        int         ack_cyc = -1;
        int         oe_low  = 0;
        logic [1:0] ack_v   = '0;
        logic [7:0] dat_v   = '0;
        mem_a[20'h12345] = 8'h5A;
        req_a = 2'b01; we_a = 2'b00; addr_a[19:0] = 20'h12345;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (!oe_a) oe_low++;
            if (ack_a !== 2'b00 && ack_cyc < 0) begin
                ack_cyc = c; ack_v = ack_a; dat_v = odata_a; req_a = 2'b00;
            end
        end
        n_tests++;
        if (ack_cyc != 2) begin n_fail++; $display("FAIL read_ack_cycle: got %0d required 2", ack_cyc); end
        n_tests++;
        if (ack_v !== 2'b01) begin n_fail++; $display("FAIL read_ack_value: got %b required 01", ack_v); end
        n_tests++;
        if (dat_v !== 8'h5A) begin n_fail++; $display("FAIL read_data: got %h required 5a", dat_v); end
        n_tests++;
        if (oe_low != 1) begin n_fail++; $display("FAIL read_oe_cycles: got %0d required 1", oe_low); end
        n_tests++;
        if (odata_a !== 8'h5A || sa_a !== 20'h12345) begin
            n_fail++;
            $display("FAIL read_hold: data %h addr %h required 5a 12345", odata_a, sa_a);
        end
    endtask

    // Channel 1 writes 0xC3 to 0xB8000 on instance b; request fields are
    // scrambled after grant and must be ignored.
    task automatic test_single_write;
        int         ack_cyc = -1;
        int         we_low = 0, doe_hi = 0;
        logic [1:0] ack_v = '0;
        mem_b[20'hB8000] = 8'h00;
        req_b = 2'b10; we_b = 2'b10; addr_b[39:20] = 20'hB8000; data_b[15:8] = 8'hC3;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin addr_b[39:20] = 20'h00001; data_b[15:8] = 8'hFF; end
            if (!wen_b) we_low++;
            if (doe_b) doe_hi++;
            if (ack_b !== 2'b00 && ack_cyc < 0) begin
                ack_cyc = c; ack_v = ack_b; req_b = 2'b00;
            end
        end
        we_b = 2'b00;
        n_tests++;
        if (we_low != 3) begin n_fail++; $display("FAIL write_we_cycles: got %0d required 3", we_low); end
        n_tests++;
        if (doe_hi != 4) begin n_fail++; $display("FAIL write_doe_cycles: got %0d required 4", doe_hi); end
        n_tests++;
        if (ack_cyc != 4) begin n_fail++; $display("FAIL write_ack_cycle: got %0d required 4", ack_cyc); end
        n_tests++;
        if (ack_v !== 2'b10) begin n_fail++; $display("FAIL write_ack_value: got %b required 10", ack_v); end
        n_tests++;
        if (mem_b[20'hB8000] !== 8'hC3) begin
            n_fail++; $display("FAIL write_mem: got %h required c3", mem_b[20'hB8000]);
        end
    endtask

    // Both channels read continuously on instance a, starting from reset.
    task automatic test_contention;
        int         n_ack = 0, last = -1, exp_ch;
        int         got_ch;
        logic [7:0] exp_d;
        rst_n_a = 1'b0;
        @(negedge clk);
        rst_n_a = 1'b1;
        mem_a[20'h00010] = 8'h11;
        mem_a[20'h00020] = 8'h22;
        addr_a = {20'h00020, 20'h00010};
        we_a = 2'b00;
        req_a = 2'b11;
        for (int c = 1; c <= 40 && n_ack < 6; c++) begin
            @(negedge clk);
            if (ack_a !== 2'b00) begin
                got_ch = (ack_a == 2'b10) ? 1 : 0;
                exp_ch = c_rr ? (n_ack % 2) : 0;
                exp_d  = (exp_ch == 1) ? 8'h22 : 8'h11;
                n_tests++;
                if (got_ch != exp_ch) begin
                    n_fail++; $display("FAIL contention_grant%0d: got ch%0d required ch%0d", n_ack, got_ch, exp_ch);
                end
                n_tests++;
                if (odata_a !== exp_d) begin
                    n_fail++; $display("FAIL contention_data%0d: got %h required %h", n_ack, odata_a, exp_d);
                end
                if (last >= 0) begin
                    n_tests++;
                    if (c - last != 3) begin
                        n_fail++; $display("FAIL contention_spacing%0d: got %0d required 3", n_ack, c - last);
                    end
                end
                last = c;
                n_ack++;
                if (n_ack == 6) req_a = 2'b00;
            end
        end
        req_a = 2'b00;
        n_tests++;
        if (n_ack != 6) begin n_fail++; $display("FAIL contention_count: got %0d required 6", n_ack); end
        @(negedge clk);
    endtask

    // Channel 0 re-requests in each post-ack IDLE cycle; writes 3 bytes.
    task automatic test_back_to_back;
        int ack_cyc [3];
        int n_ack = 0, ce_hi = 0;
        bit pending = 1'b0;
        for (int i = 0; i < 3; i++) ack_cyc[i] = -1;
        we_a = 2'b01; addr_a[19:0] = 20'h00100; data_a[7:0] = 8'hA0;
        req_a = 2'b01;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 8 && ce1_a) ce_hi++;
            if (pending) begin
                pending = 1'b0;
                addr_a[19:0] = 20'h00100 + 20'(n_ack);
                data_a[7:0]  = 8'hA0 + 8'(n_ack);
                req_a = 2'b01;
            end
            if (ack_a !== 2'b00 && n_ack < 3) begin
                ack_cyc[n_ack] = c;
                n_ack++;
                req_a = 2'b00;
                pending = (n_ack < 3);
            end
        end
        we_a = 2'b00;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (ack_cyc[i] != 2 + 3 * i) begin
                n_fail++; $display("FAIL b2b_ack%0d: got cycle %0d required %0d", i, ack_cyc[i], 2 + 3 * i);
            end
        end
        n_tests++;
        if (ce_hi != 2) begin n_fail++; $display("FAIL b2b_idle_cycles: got %0d required 2", ce_hi); end
        n_tests++;
        if ({mem_a[20'h00100], mem_a[20'h00101], mem_a[20'h00102]} !== 24'hA0A1A2) begin
            n_fail++;
            $display("FAIL b2b_mem: got %h%h%h required a0a1a2", mem_a[20'h00100], mem_a[20'h00101], mem_a[20'h00102]);
        end
    endtask

    // Channel 0 write on instance b aborted by reset during ACCESS.
    task automatic test_reset_mid_write;
        int         ack_cyc = -1;
        logic [1:0] ack_v = '0;
        bit         ack_in_rst = 1'b0;
        addr_b = {20'h00400, 20'h00300};
        data_b = {8'h00, 8'hAA};
        we_b   = 2'b01;
        req_b  = 2'b01;
        @(negedge clk);
        n_tests++;
        if (wen_b !== 1'b0) begin n_fail++; $display("FAIL rst_pre_we: got %b required 0", wen_b); end
        #10 rst_n_b = 1'b0;
        #1;
        n_tests++;
        if ({wen_b, doe_b, ce1_b, ack_b} !== 5'b10100) begin
            n_fail++; $display("FAIL rst_async_pins: we_n/doe/ce1_n/ack got %b required 10100", {wen_b, doe_b, ce1_b, ack_b});
        end
        req_b = 2'b11;
        repeat (3) begin
            @(negedge clk);
            if (ack_b !== 2'b00) ack_in_rst = 1'b1;
        end
        n_tests++;
        if (ack_in_rst) begin n_fail++; $display("FAIL rst_no_ack: got ack during reset required none"); end
        rst_n_b = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ack_b !== 2'b00 && ack_cyc < 0) begin
                ack_cyc = c; ack_v = ack_b; req_b = 2'b00;
            end
        end
        we_b = 2'b00;
        n_tests++;
        if (ack_v !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant: got %b required 01", ack_v); end
        n_tests++;
        if (mem_b[20'h00300] !== 8'hAA) begin
            n_fail++; $display("FAIL rst_reissue_mem: got %h required aa", mem_b[20'h00300]);
        end
    endtask

    initial begin
        for (int i = 0; i < 1048576; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        @(negedge clk);
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
